// File: rtl/mux_pkg.sv
// Shared definitions for the streaming multiplexer family.
package mux_pkg;

  localparam int PTR_RST = 0;

  // Select/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, pick the lowest set bit, rotate back.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic              adv,
  output logic [NUM_CH-1:0] grant
);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    gnt_idx;
  logic [NUM_CH-1:0]   rot_req;
  logic [NUM_CH-1:0]   rot_gnt;
  logic [2*NUM_CH-1:0] rot_back;

  // Doubling the vector turns a modulo-NUM_CH rotate into a plain shift.
  assign rot_req  = NUM_CH'({req, req} >> ptr);
  assign rot_gnt  = rot_req & (~rot_req + NUM_CH'(1));
  assign rot_back = {rot_gnt, rot_gnt} << ptr;
  assign grant    = en ? rot_back[2*NUM_CH-1:NUM_CH] : '0;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) gnt_idx = gnt_idx | SEL_W'(i);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= SEL_W'(PTR_RST);
    else if (adv)
      ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + SEL_W'(1);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with registered output; fixed-select or round-robin grant.
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     rr_en,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] fix_grant;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  mux_ch;

  assign load_en = !out_valid || out_ready;

  // An out-of-range sel matches no channel, so it simply yields no grant.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel == SEL_W'(i)) fix_grant[i] = in_valid[i];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (in_valid),
    .en    (rr_en),
    .adv   (rr_en && xfer),
    .grant (rr_grant)
  );

  assign grant    = rr_en ? rr_grant : fix_grant;
  assign in_ready = {NUM_CH{load_en}} & grant;
  assign xfer     = |(in_valid & in_ready);

  // AND-OR select over a one-hot grant.
  always_comb begin
    mux_data = '0;
    mux_ch   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mux_data = mux_data | ({DATA_W{grant[i]}} & in_data[i*DATA_W +: DATA_W]);
      if (grant[i]) mux_ch = mux_ch | SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        out_ch   <= mux_ch;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with NUM_CH = 4, DATA_W = 4.
module tb_stream_mux_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     rr_en;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    in_data = 16'h000A; in_valid = 4'b0000; rr_en = 1'b0; sel = 2'd0; out_ready = 1'b1;
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    // Load 4'hA from channel 0 and keep it held.
    in_valid = 4'b0001; tick();
    in_valid = 4'b0000; out_ready = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin bad++; $display("FAIL reset_preload got=%b/%h exp=1/a", out_valid, out_data); end
    rst = 1'b1; #1;
    total++; if ({out_valid, out_data, out_ch} !== 7'd0) begin bad++; $display("FAIL reset_async got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_ch); end
    #2 rst = 1'b0; #1;
    rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
    in_valid = 4'b0000;
  endtask

  task automatic test_fixed();
    do_reset();
    rr_en = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 16'h3C15; out_ready = 1'b1; #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 4'hC || out_ch !== 2'd2 || in_ready !== 4'b0100) begin
        bad++; $display("FAIL fixed_cycle%0d got=%b/%h/%0d/%b exp=1/c/2/0100", c, out_valid, out_data, out_ch, in_ready);
      end
    end
  endtask

  task automatic test_rr_fair();
    logic [SEL_W-1:0]  exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [DATA_W-1:0] exp_d  [6] = '{4'h5, 4'h1, 4'hC, 4'h3, 4'h5, 4'h1};
    do_reset();
    rr_en = 1'b1; in_valid = 4'b1111; in_data = 16'h3C15; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== exp_ch[c] || out_data !== exp_d[c]) begin
        bad++; $display("FAIL rr_fair_%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_valid, out_ch, out_data, exp_ch[c], exp_d[c]);
      end
    end
  endtask

  // Runs straight after test_rr_fair, which leaves ptr = 2.
  task automatic test_rr_sparse();
    logic [SEL_W-1:0] exp_ch [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
    in_valid = 4'b1010; #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL rr_sparse_first got=%b exp=1000", in_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== exp_ch[c]) begin
        bad++; $display("FAIL rr_sparse_%0d got=%b/%0d exp=1/%0d", c, out_valid, out_ch, exp_ch[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rr_en = 1'b1; in_data = 16'h4217; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== 4'h7 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold_%0d got=%b/%h/%0d/%b exp=1/7/0/0000", c, out_valid, out_data, out_ch, in_ready);
      end
      tick();
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h1 || out_ch !== 2'd1) begin
      bad++; $display("FAIL bp_next_word got=%b/%h/%0d exp=1/1/1", out_valid, out_data, out_ch);
    end
  endtask

  // Runs straight after test_backpressure, which leaves channel 1's word (4'h1) held.
  task automatic test_empty_sel();
    rr_en = 1'b0; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b0; #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL empty_stalled got=%b exp=0000", in_ready); end
    tick();
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL empty_no_grant got=%b exp=0000", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 4'h1 || out_ch !== 2'd1) begin
      bad++; $display("FAIL empty_drain got=%b/%h/%0d exp=0/1/1", out_valid, out_data, out_ch);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; rr_en = 1'b0; sel = '0; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_empty_sel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
